led_flow_ctrl: RTL

Sequencer for the flowing-LED bank: steps a single lit position across `N_LED` outputs at a fixed step period. Within each step the lit LED is on only for the first `ON_CYC` cycles, giving a programmable duty cycle. It replaces free-running per-LED blink counters with one shared tick counter and a position scheduler, and sits directly between board clock/reset, user controls and the LED pins.

---
 rtl/led_flow_pkg.sv | 22 ++
 rtl/led_flow_ctrl_tick_gen.sv | 43 ++++
 rtl/led_flow_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_flow_pkg.sv
// Shared types for the flowing-LED sequencer: FSM states, mode encodings, scan direction.
package led_flow_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_LEFT     = 2'b00,
        MODE_RIGHT    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_flow_ctrl_tick_gen.sv
// Step-period counter: counts 0..STEP_CYC-1 while enabled, held at zero otherwise.
// Exposes the next count so the parent can register outputs from next-state values.
module led_tick_gen #(
    parameter int unsigned STEP_CYC = 8,
    parameter int unsigned CW       = $clog2(STEP_CYC)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic [CW-1:0] cnt_nxt_o,
    output logic          step_o
);

    localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        // Count never reaches LAST while disabled, so the pulse needs no extra gating.
        step_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign step_o    = step_q;

endmodule

// File: rtl/led_flow_ctrl.sv
// Flowing-LED sequencer: one lit position stepped across N_LED pins with a duty-cycled on time.
// Ping-pong mode and its direction register exist only when LED_FLOW_PINGPONG_EN is defined.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned STEP_CYC = 5_000_000,
    parameter int unsigned ON_CYC   = 1_250_000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic             Stop,
    input  logic [1:0]       Mode,
    output logic [N_LED-1:0] LED_out,
    output logic             Busy,
    output logic             Step
);

    localparam int unsigned CW = $clog2(STEP_CYC);
    localparam int unsigned PW = $clog2(N_LED);
    localparam logic [CW-1:0]    LAST = CW'(STEP_CYC - 1);
    localparam logic [PW-1:0]    PMAX = PW'(N_LED - 1);
    localparam logic [N_LED-1:0] ONE  = N_LED'(1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              term;
`ifdef LED_FLOW_PINGPONG_EN
    dir_e              dir_q, dir_d;
`endif

    led_tick_gen #(
        .STEP_CYC (STEP_CYC),
        .CW       (CW)
    ) u_tick (
        .clk_i     (CLK),
        .rst_ni    (RSTn),
        .en_i      (state_q != IDLE),
        .cnt_o     (cnt_q),
        .cnt_nxt_o (cnt_d),
        .step_o    (Step)
    );

    assign term = (state_q != IDLE) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
`ifdef LED_FLOW_PINGPONG_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start && !Stop) begin
                    state_d = RUN;
                    mode_d  = mode_e'(Mode);
                    pos_d   = (mode_e'(Mode) == MODE_RIGHT) ? PMAX : '0;
`ifdef LED_FLOW_PINGPONG_EN
                    dir_d   = DIR_UP;
`endif
                end
            end
            RUN: begin
                if (Stop) state_d = STOPPING;
                if (term) begin
                    if (mode_q == MODE_RIGHT) begin
                        pos_d = (pos_q == '0) ? PMAX : pos_q - PW'(1);
`ifdef LED_FLOW_PINGPONG_EN
                    end else if (mode_q == MODE_PINGPONG) begin
                        // Bounce at the ends without relighting the end LED.
                        if (dir_q == DIR_UP) begin
                            if (pos_q == PMAX) begin
                                pos_d = pos_q - PW'(1);
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = PW'(1);
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q - PW'(1);
                            end
                        end
`endif
                    end else begin
                        pos_d = (pos_q == PMAX) ? '0 : pos_q + PW'(1);
                    end
                end
            end
            STOPPING: begin
                if (term) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        led_d  = '0;
        if (busy_d && (32'(cnt_d) < ON_CYC)) begin
            led_d = ONE << pos_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            mode_q  <= MODE_LEFT;
            pos_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
`ifdef LED_FLOW_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign LED_out = led_q;
    assign Busy    = busy_q;

endmodule
